// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM states, queued command
// layout and the fixed cycle-type encoding.
package wb_master_pkg;

    // Field widths of a queued command; wb_cmd_master's DW/AW must match these.
    localparam int WB_DW = 32;
    localparam int WB_AW = 26;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    typedef enum logic [1:0] {
        INIT_WAIT = 2'd0,
        IDLE      = 2'd1,
        BUS       = 2'd2,
        RESP      = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic                 we;
        logic [WB_AW-1:0]     addr;
        logic [WB_DW-1:0]     data;
        logic [WB_DW/8-1:0]   sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command queue in front of the Wishbone master. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate count.
module wb_cmd_fifo
    import wb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    sys_clk,
    input  logic    RESETN,
    input  logic    push,
    input  wb_cmd_t push_cmd,
    input  logic    pop,
    output wb_cmd_t head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    wb_cmd_t     mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge sys_clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= push_cmd;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master feeding the SDRAM controller. Queued
// commands are issued one at a time after SDRAM init; each produces a single
// response pulse carrying read data or a timeout error.
//
// state     | meaning
// INIT_WAIT | SDRAM not ready; commands may queue but none issue
// IDLE      | bus quiet; pop next command when one is queued
// BUS       | stb/cyc asserted, waiting for ack or timeout
// RESP      | one-cycle response pulse, bus forced idle
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int DW          = WB_DW,
    parameter int AW          = WB_AW,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_data,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    output logic            rsp_we,
    output logic            rsp_err,
    output logic [DW-1:0]   rsp_data,
    output logic            busy,
    input  logic            sdr_init_done,
    output logic            wb_stb_i,
    output logic            wb_cyc_i,
    output logic            wb_we_i,
    output logic [AW-1:0]   wb_addr_i,
    output logic [DW-1:0]   wb_dat_i,
    output logic [DW/8-1:0] wb_sel_i,
    output logic [2:0]      wb_cti_i,
    input  logic            wb_ack_o,
    input  logic [DW-1:0]   wb_dat_o
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    wb_state_t     state;
    logic [TW-1:0] tmo_cnt;

    wb_cmd_t push_cmd;
    wb_cmd_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;

    assign push_cmd.we   = cmd_we;
    assign push_cmd.addr = cmd_addr;
    assign push_cmd.data = cmd_data;
    assign push_cmd.sel  = cmd_sel;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && sdr_init_done && !fifo_empty;
    assign busy      = !fifo_empty || (state == BUS) || (state == RESP);
    assign wb_cti_i  = CTI_CLASSIC;

    wb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .RESETN   (RESETN),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Sequencer: issues one command, waits for ack or timeout, pulses response.
    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state     <= INIT_WAIT;
            tmo_cnt   <= '0;
            wb_stb_i  <= 1'b0;
            wb_cyc_i  <= 1'b0;
            wb_we_i   <= 1'b0;
            wb_addr_i <= '0;
            wb_dat_i  <= '0;
            wb_sel_i  <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                INIT_WAIT: begin
                    if (sdr_init_done)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!sdr_init_done) begin
                        state <= INIT_WAIT;
                    end else if (!fifo_empty) begin
                        wb_stb_i  <= 1'b1;
                        wb_cyc_i  <= 1'b1;
                        wb_we_i   <= head.we;
                        wb_addr_i <= head.addr;
                        // Reads drive no data and select every byte lane.
                        wb_dat_i  <= head.we ? head.data : '0;
                        wb_sel_i  <= head.we ? head.sel : '1;
                        tmo_cnt   <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Init dropping here is deliberately ignored: finish the cycle.
                    if (wb_ack_o || (tmo_cnt == TMO_LAST)) begin
                        wb_stb_i  <= 1'b0;
                        wb_cyc_i  <= 1'b0;
                        wb_we_i   <= 1'b0;
                        wb_addr_i <= '0;
                        wb_dat_i  <= '0;
                        wb_sel_i  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= wb_we_i;
                        rsp_err   <= !wb_ack_o;
                        rsp_data  <= (wb_ack_o && !wb_we_i) ? wb_dat_o : '0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_we    <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    state     <= IDLE;
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

endmodule
